// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: request/response handshake and data_memory port bundle
// for the MIPS MEM-stage load/store unit.
//   req_*   : byte-addressed load/store request (valid/ready handshake)
//   resp_*  : one-cycle completion pulse with load data and error flag
//   dm_*    : word-addressed data_memory port (dm_rd is combinational)
// Modports:
//   master : requester plus memory side (drives req_* and dm_rd)
//   slave  : the load/store unit (drives req_ready, resp_*, dm_addr/wd/we)
interface mem_access_unit_if #(
    parameter int unsigned ADDR_W = 12
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;

    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_wd;
    logic              dm_we;
    logic [31:0]       dm_rd;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output dm_rd,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  dm_addr, dm_wd, dm_we
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  dm_rd,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output dm_addr, dm_wd, dm_we
    );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store front end between the MIPS MEM stage and a
// word-addressed data_memory. Byte/half/word loads return the addressed
// little-endian lane, sign- or zero-extended. Sub-word stores do a
// read-modify-write of the containing 32-bit word.
// Ports:
//   clk    : clock, all state changes on posedge
//   rst_n  : synchronous reset, active low
//   bus    : mem_access_unit_if.slave (req_*, resp_*, dm_*)
// Configuration macro: MAU_ALIGN_CHECK_EN
//   defined   : misaligned half/word requests complete with resp_err=1 and
//               never touch memory
//   undefined : no error state; offending low address bits are cleared and
//               the access proceeds as aligned; resp_err is always 0
module mem_access_unit #(
    parameter int unsigned ADDR_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_access_unit_if.slave bus
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BA_W   = ADDR_W + 2;   // byte-address bits that matter

`ifdef MAU_ALIGN_CHECK_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCESS = 3'd1,
        S_READ   = 3'd2,
        S_WRITE  = 3'd3,
        S_ERR    = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCESS = 3'd1,
        S_READ   = 3'd2,
        S_WRITE  = 3'd3
    } state_t;
`endif

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_we;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic [BA_W-1:0]   r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_merge;
    logic              r_resp_valid;
    logic [DATA_W-1:0] r_resp_rdata;

    logic              w_fire;
    logic              w_is_word;
    logic              w_is_half;
    logic              w_misaligned;
    logic [BA_W-1:0]   w_req_addr;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [DATA_W-1:0] w_load;
    logic [DATA_W-1:0] w_merge;
    logic              w_ready;
    logic              w_dm_we;
    logic [DATA_W-1:0] w_dm_wd;
    logic [ADDR_W-1:0] w_dm_addr;
    logic              w_unused_addr;

    // Address bits above the memory range are don't-care
    assign w_unused_addr = ^bus.req_addr[DATA_W-1:BA_W];

    // Incoming request classification; size 11 behaves as word
    assign w_is_word = bus.req_size[1];
    assign w_is_half = (bus.req_size == 2'b01);
    assign w_fire    = bus.req_valid & (r_state == S_IDLE);

`ifdef MAU_ALIGN_CHECK_EN
    assign w_misaligned = (w_is_half & bus.req_addr[0])
                        | (w_is_word & (bus.req_addr[1:0] != 2'b00));
    assign w_req_addr   = bus.req_addr[BA_W-1:0];
`else
    // Clear the offending low bits so the access runs as aligned
    assign w_misaligned = 1'b0;
    assign w_req_addr   = {bus.req_addr[BA_W-1:2],
                           bus.req_addr[1] & ~w_is_word,
                           bus.req_addr[0] & ~(w_is_word | w_is_half)};
`endif

    // Load lane select and extension from the latched request
    always_comb begin
        w_byte = bus.dm_rd[{r_addr[1:0], 3'b000} +: 8];
        w_half = bus.dm_rd[{r_addr[1], 4'b0000} +: 16];
        case (r_size)
            2'b00:   w_load = r_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'b01:   w_load = r_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_load = bus.dm_rd;
        endcase
    end

    // RMW merge: current word with the addressed lane replaced by store data
    always_comb begin
        w_merge = bus.dm_rd;
        if (r_size == 2'b00) begin
            w_merge[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
        end else begin
            w_merge[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and memory-port outputs
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_dm_we     = 1'b0;
        w_dm_wd     = r_wdata;
        w_dm_addr   = r_addr[BA_W-1:2];
        case (r_state)
            S_IDLE: begin
                w_ready   = 1'b1;
                w_dm_addr = bus.req_addr[BA_W-1:2];
                if (w_fire) begin
`ifdef MAU_ALIGN_CHECK_EN
                    if (w_misaligned) begin
                        w_state_nxt = S_ERR;
                    end else
`endif
                    if (bus.req_we && !w_is_word) begin
                        w_state_nxt = S_READ;
                    end else begin
                        w_state_nxt = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                w_dm_we     = r_we;
                w_state_nxt = S_IDLE;
            end
            S_READ: begin
                w_state_nxt = S_WRITE;
            end
            S_WRITE: begin
                w_dm_we     = 1'b1;
                w_dm_wd     = r_merge;
                w_state_nxt = S_IDLE;
            end
`ifdef MAU_ALIGN_CHECK_EN
            S_ERR: begin
                w_state_nxt = S_IDLE;
            end
`endif
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Request latch, merge register and registered response
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_we         <= 1'b0;
            r_size       <= 2'b00;
            r_unsigned   <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_merge      <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            if (w_fire) begin
                r_we       <= bus.req_we;
                r_size     <= bus.req_size;
                r_unsigned <= bus.req_unsigned;
                r_addr     <= w_req_addr;
                r_wdata    <= bus.req_wdata;
            end
            case (r_state)
                S_ACCESS: begin
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= r_we ? '0 : w_load;
                end
                S_READ: begin
                    r_merge <= w_merge;
                end
                S_WRITE: begin
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= '0;
                end
`ifdef MAU_ALIGN_CHECK_EN
                S_ERR: begin
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= '0;
                end
`endif
                default: begin
                end
            endcase
        end
    end

`ifdef MAU_ALIGN_CHECK_EN
    logic r_resp_err;

    // Error flag accompanies the completion pulse of a misaligned request
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_resp_err <= 1'b0;
        end else if (r_state == S_ERR) begin
            r_resp_err <= 1'b1;
        end else if ((r_state == S_ACCESS) || (r_state == S_WRITE)) begin
            r_resp_err <= 1'b0;
        end
    end

    assign bus.resp_err = r_resp_err;
`else
    assign bus.resp_err = 1'b0;
`endif

    // No write may land on a reset edge, even mid-RMW
    assign bus.dm_we      = w_dm_we & rst_n;
    assign bus.dm_wd      = w_dm_wd;
    assign bus.dm_addr    = w_dm_addr;
    assign bus.req_ready  = w_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_resp_rdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed vector table, reset-during-RMW and
// back-to-back sequences, then random requests against a byte-array model.
module tb_mem_access_unit;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned NWORDS = 1 << ADDR_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_access_unit_if #(.ADDR_W(ADDR_W)) bus ();

    mem_access_unit #(.ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Word memory seen by the DUT
    logic [31:0] mem [NWORDS];
    logic        mem_init = 1'b0;
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < int'(NWORDS); i++) mem[i] <= (i == 10) ? 32'd100 : 32'd0;
        end else if (bus.dm_we) begin
            mem[bus.dm_addr] <= bus.dm_wd;
        end
    end
    assign bus.dm_rd = mem[bus.dm_addr];

    // Reference model: flat byte array
    logic [7:0] rbytes [NWORDS*4];

    int n_err    = 0;
    int n_checks = 0;
    int cyc      = 0;
    int n_we     = 0;

    typedef struct {
        int          c;
        logic [31:0] rd;
        logic        err;
    } rsp_t;
    int   acc_q[$];
    rsp_t rsp_q[$];

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (bus.dm_we) n_we <= n_we + 1;

    // Handshake recorded in the cycle it fires; response in the cycle it is seen
    always @(negedge clk) begin
        if (bus.req_valid && bus.req_ready && rst_n) acc_q.push_back(cyc);
        if (bus.resp_valid) rsp_q.push_back('{cyc, bus.resp_rdata, bus.resp_err});
    end

    typedef struct {
        logic        init;
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] erd;
        logic        eerr;
        int          elat;
    } vec_t;
    vec_t vecs[$];

    function automatic vec_t mk(input logic init, input logic we, input logic [1:0] sz,
                                input logic uns, input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] erd, input logic eerr, input int elat);
        vec_t v;
        v.init = init; v.we = we; v.sz = sz; v.uns = uns; v.addr = a; v.wd = wd;
        v.erd = erd; v.eerr = eerr; v.elat = elat;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", nm, act, exp);
        end
    endtask

    task automatic init_all();
        for (int i = 0; i < int'(NWORDS*4); i++) rbytes[i] = 8'h00;
        rbytes[40] = 8'd100;
        mem_init = 1'b1;
        @(posedge clk); #1;
        mem_init = 1'b0;
    endtask

    // Expected result of one request computed from byte-level semantics
    task automatic ref_access(input logic we, input logic [1:0] sz, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wd,
                              output logic [31:0] rd, output logic err, output int lat);
        int a;
        int n;
        logic [31:0] v;
        a   = int'(addr % (NWORDS*4));
        n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        err = 1'b0;
        rd  = 32'd0;
        lat = 2;
        if ((a % n) != 0) begin
`ifdef MAU_ALIGN_CHECK_EN
            err = 1'b1;
            return;
`else
            a = a - (a % n);
`endif
        end
        if (we) begin
            for (int i = 0; i < n; i++) rbytes[a+i] = wd[8*i +: 8];
            lat = (n == 4) ? 2 : 3;
        end else begin
            v = 32'd0;
            for (int i = 0; i < n; i++) v = v | (32'(rbytes[a+i]) << (8*i));
            if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
            rd = v;
        end
    endtask

    task automatic drive(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd);
        bus.req_we       = we;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = a;
        bus.req_wdata    = wd;
    endtask

    // One request with bounded waits; lat counts cycles from handshake to resp_valid
    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd, input string nm,
                         output logic [31:0] rd, output logic er, output int lat);
        int   n;
        rsp_t r;
        rd = 32'hDEAD_BEEF; er = 1'bx; lat = -1;
        @(posedge clk); #1;
        acc_q.delete(); rsp_q.delete();
        drive(we, sz, uns, a, wd);
        bus.req_valid = 1'b1;
        n = 0;
        while (acc_q.size() == 0 && n < 20) begin @(negedge clk); #1; n++; end
        if (acc_q.size() == 0) begin
            chk({nm, " accept timeout"}, 32'd0, 32'd1);
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        n = 0;
        while (rsp_q.size() == 0 && n < 10) begin @(negedge clk); #1; n++; end
        if (rsp_q.size() == 0) begin
            chk({nm, " resp timeout"}, 32'd0, 32'd1);
            return;
        end
        r   = rsp_q.pop_front();
        rd  = r.rd;
        er  = r.err;
        lat = r.c - acc_q[0];
    endtask

    logic [31:0] rd, erd;
    logic        er, eer;
    int          lat, elat, w0, k, guard;
    logic        fire;
    logic        bb_we [4];
    logic [31:0] bb_a  [4];
    logic [31:0] bb_wd [4];
    logic [31:0] bb_rd [4];

    initial begin
        bus.req_valid = 1'b0;
        drive(1'b0, 2'b10, 1'b0, 32'd0, 32'd0);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("reset resp_rdata", bus.resp_rdata, 32'd0);
        chk("reset resp_err",   32'(bus.resp_err), 32'd0);
        chk("reset req_ready",  32'(bus.req_ready), 32'd1);
        chk("reset dm_we",      32'(bus.dm_we), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed vectors: {init, we, size, uns, addr, wdata, exp rdata, exp err, exp latency}
        vecs.push_back(mk(1, 0, 2'b10, 0, 32'h28, 0,            32'h0000_0064, 0, 2));
        vecs.push_back(mk(1, 1, 2'b00, 0, 32'h29, 32'h0000_00AB, 32'h0,        0, 3));
        vecs.push_back(mk(0, 0, 2'b00, 0, 32'h29, 0,            32'hFFFF_FFAB, 0, 2));
        vecs.push_back(mk(0, 0, 2'b00, 1, 32'h29, 0,            32'h0000_00AB, 0, 2));
        vecs.push_back(mk(0, 0, 2'b10, 0, 32'h28, 0,            32'h0000_AB64, 0, 2));
        vecs.push_back(mk(1, 1, 2'b01, 0, 32'h2A, 32'h0000_8001, 32'h0,        0, 3));
        vecs.push_back(mk(0, 0, 2'b10, 0, 32'h28, 0,            32'h8001_0064, 0, 2));
        vecs.push_back(mk(0, 0, 2'b01, 0, 32'h2A, 0,            32'hFFFF_8001, 0, 2));
        vecs.push_back(mk(0, 0, 2'b01, 1, 32'h2A, 0,            32'h0000_8001, 0, 2));
        vecs.push_back(mk(0, 0, 2'b00, 0, 32'h2B, 0,            32'hFFFF_FF80, 0, 2));
        vecs.push_back(mk(1, 1, 2'b10, 0, 32'h2C, 32'hCAFE_F00D, 32'h0,        0, 2));
        vecs.push_back(mk(0, 0, 2'b11, 0, 32'h2C, 0,            32'hCAFE_F00D, 0, 2));
        vecs.push_back(mk(1, 1, 2'b00, 0, 32'h2B, 32'h1234_565A, 32'h0,        0, 3));
        vecs.push_back(mk(0, 0, 2'b10, 1, 32'h28, 0,            32'h5A00_0064, 0, 2));
`ifdef MAU_ALIGN_CHECK_EN
        vecs.push_back(mk(1, 1, 2'b10, 0, 32'h2B, 32'h1234_5678, 32'h0,        1, 2));
        vecs.push_back(mk(0, 0, 2'b10, 0, 32'h28, 0,            32'h0000_0064, 0, 2));
        vecs.push_back(mk(1, 0, 2'b01, 0, 32'h29, 0,            32'h0,         1, 2));
`else
        vecs.push_back(mk(1, 1, 2'b10, 0, 32'h2B, 32'h1234_5678, 32'h0,        0, 2));
        vecs.push_back(mk(0, 0, 2'b10, 0, 32'h28, 0,            32'h1234_5678, 0, 2));
        vecs.push_back(mk(1, 0, 2'b01, 0, 32'h29, 0,            32'h0000_0064, 0, 2));
`endif
        foreach (vecs[i]) begin
            if (vecs[i].init) init_all();
            w0 = n_we;
            issue(vecs[i].we, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wd,
                  $sformatf("vec%0d", i), rd, er, lat);
            chk($sformatf("vec%0d rdata", i), rd, vecs[i].erd);
            chk($sformatf("vec%0d err", i), 32'(er), 32'(vecs[i].eerr));
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].elat));
            chk($sformatf("vec%0d writes", i), 32'(n_we - w0),
                (vecs[i].we && !vecs[i].eerr) ? 32'd1 : 32'd0);
        end

        // Reset while an sb is in WRITE: store dropped, no completion
        init_all();
        acc_q.delete(); rsp_q.delete();
        drive(1'b1, 2'b00, 1'b0, 32'h28, 32'h0000_00FF);
        bus.req_valid = 1'b1;
        guard = 0;
        while (acc_q.size() == 0 && guard < 20) begin @(negedge clk); #1; guard++; end
        chk("rst-rmw accepted", 32'(acc_q.size()), 32'd1);
        @(posedge clk); #1;                 // READ
        bus.req_valid = 1'b0;
        @(posedge clk); #1;                 // WRITE
        chk("rst-rmw dm_we in WRITE", 32'(bus.dm_we), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst-rmw dm_we gated", 32'(bus.dm_we), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("rst-rmw req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst-rmw resp_valid", 32'(bus.resp_valid), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst-rmw word10", mem[10], 32'h0000_0064);
        chk("rst-rmw no resp", 32'(rsp_q.size()), 32'd0);
        ref_access(1'b0, 2'b10, 1'b0, 32'h28, 32'd0, erd, eer, elat);
        issue(1'b0, 2'b10, 1'b0, 32'h28, 32'd0, "rst-rmw lw", rd, er, lat);
        chk("rst-rmw lw rdata", rd, erd);

        // Back-to-back: req_valid held, alternating sw/lw
        init_all();
        bb_we[0] = 1'b1; bb_a[0] = 32'h28; bb_wd[0] = 32'h1111_1111;
        bb_we[1] = 1'b0; bb_a[1] = 32'h28; bb_wd[1] = 32'h0;
        bb_we[2] = 1'b1; bb_a[2] = 32'h2C; bb_wd[2] = 32'h2222_2222;
        bb_we[3] = 1'b0; bb_a[3] = 32'h2C; bb_wd[3] = 32'h0;
        for (int i = 0; i < 4; i++) ref_access(bb_we[i], 2'b10, 1'b0, bb_a[i], bb_wd[i], bb_rd[i], eer, elat);
        acc_q.delete(); rsp_q.delete();
        k = 0;
        drive(bb_we[0], 2'b10, 1'b0, bb_a[0], bb_wd[0]);
        bus.req_valid = 1'b1;
        guard = 0;
        while (k < 4 && guard < 40) begin
            @(negedge clk);
            fire = bus.req_ready;
            @(posedge clk); #1;
            guard++;
            if (fire) begin
                k++;
                if (k < 4) drive(bb_we[k], 2'b10, 1'b0, bb_a[k], bb_wd[k]);
                else bus.req_valid = 1'b0;
            end
        end
        guard = 0;
        while (rsp_q.size() < 4 && guard < 10) begin @(negedge clk); #1; guard++; end
        repeat (3) @(posedge clk);
        #1;
        chk("b2b accepts", 32'(acc_q.size()), 32'd4);
        chk("b2b responses", 32'(rsp_q.size()), 32'd4);
        if (acc_q.size() == 4 && rsp_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("b2b%0d rdata", i), rsp_q[i].rd, bb_rd[i]);
                chk($sformatf("b2b%0d latency", i), 32'(rsp_q[i].c - acc_q[i]), 32'd2);
                if (i < 3) chk($sformatf("b2b%0d accept on resp", i + 1), 32'(acc_q[i+1]), 32'(rsp_q[i].c));
            end
        end

        // Random requests against the byte model
        init_all();
        for (int i = 0; i < 150; i++) begin
            logic        r_we, r_uns;
            logic [1:0]  r_sz;
            logic [31:0] r_a, r_wd;
            r_we  = 1'($urandom_range(0, 1));
            r_uns = 1'($urandom_range(0, 1));
            r_sz  = 2'($urandom_range(0, 3));
            r_a   = ($urandom & 32'hFFFF_C000) | 32'($urandom_range(32, 63));
            r_wd  = $urandom;
            ref_access(r_we, r_sz, r_uns, r_a, r_wd, erd, eer, elat);
            issue(r_we, r_sz, r_uns, r_a, r_wd, $sformatf("rnd%0d", i), rd, er, lat);
            chk($sformatf("rnd%0d rdata", i), rd, erd);
            chk($sformatf("rnd%0d err", i), 32'(er), 32'(eer));
            chk($sformatf("rnd%0d latency", i), 32'(lat), 32'(elat));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
